// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg
// Shared constants and helpers for the SR request conditioner slice.
//   DEBOUNCE_CYCLES_DEF : default number of stable synchronised samples
//                         needed before a debounced level changes
//   DROP_CNT_W_DEF      : default width of the saturating dropped-set counter
//   cntWidth()          : width of the debounce counter for a given
//                         debounce length (must hold 0..DEBOUNCE_CYCLES)
// ---------------------------------------------------------------------------
package sr_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int DROP_CNT_W_DEF      = 8;

  // A one-cycle debounce still needs a 1-bit counter so the port widths
  // never collapse to zero.
  function automatic int cntWidth(input int debounceCycles);
    return (debounceCycles < 2) ? 1 : $clog2(debounceCycles + 1);
  endfunction

endpackage

// File: rtl/sr_debounce_ch.sv
// ---------------------------------------------------------------------------
// sr_debounce_ch
// One request channel: two-flop synchroniser, debounce counter and a
// one-cycle event on each accepted rising level change.
//   Clk       : system clock, rising edge
//   Rst_n     : asynchronous active-low reset
//   raw_in    : raw request, asynchronous to Clk, may bounce
//   ev_out    : one-cycle pulse when the debounced level rises
//   level_out : current debounced level (observation only)
// ---------------------------------------------------------------------------
module sr_debounce_ch
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic raw_in,
  output logic ev_out,
  output logic level_out
);

  localparam int CW = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_ev;
  logic [CW-1:0] r_cnt;

  // Two-flop synchroniser bringing the raw request into the Clk domain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // The counter tracks how long the synchronised level has disagreed with
  // the debounced level; any agreeing sample restarts it, so a glitch
  // shorter than DEBOUNCE_CYCLES samples never changes the level. The event
  // copies the new level, which makes falling transitions silent.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_deb <= 1'b0;
      r_cnt <= '0;
      r_ev  <= 1'b0;
    end else begin
      r_ev <= 1'b0;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
        r_ev  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ev_out    = r_ev;
  assign level_out = r_deb;

endmodule

// File: rtl/sr_request_conditioner.sv
// ---------------------------------------------------------------------------
// sr_request_conditioner
// Conditions raw set/reset requests for the downstream SR flip-flop and
// arbitrates them so S and R are never high in the same cycle.
//   Clk      : system clock, rising edge
//   Rst_n    : asynchronous active-low reset
//   S_raw    : raw set request, asynchronous, may bounce
//   R_raw    : raw reset request, asynchronous, may bounce
//   S        : registered one-cycle set pulse
//   R        : registered one-cycle reset pulse
//   Conflict : one-cycle pulse alongside R when a set event was discarded
//   Drop_cnt : saturating count of discarded set events
// ---------------------------------------------------------------------------
module sr_request_conditioner
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DROP_CNT_W      = DROP_CNT_W_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  S_raw,
  input  logic                  R_raw,
  output logic                  S,
  output logic                  R,
  output logic                  Conflict,
  output logic [DROP_CNT_W-1:0] Drop_cnt
);

  logic                  w_evS;
  logic                  w_evR;
  logic                  w_unusedSLevel;
  logic                  w_unusedRLevel;
  logic                  r_s;
  logic                  r_r;
  logic                  r_conflict;
  logic [DROP_CNT_W-1:0] r_dropCnt;

  // Debounced levels are only brought out for observation in simulation.
  sr_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sCh (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .raw_in   (S_raw),
    .ev_out   (w_evS),
    .level_out(w_unusedSLevel)
  );

  sr_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rCh (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .raw_in   (R_raw),
    .ev_out   (w_evR),
    .level_out(w_unusedRLevel)
  );

  // Reset has priority: a set arriving together with a reset is thrown
  // away rather than queued, so the flip-flop never sees S and R together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
      r_dropCnt  <= '0;
    end else begin
      r_s        <= w_evS & ~w_evR;
      r_r        <= w_evR;
      r_conflict <= w_evS & w_evR;
      if (w_evS && w_evR && (r_dropCnt != {DROP_CNT_W{1'b1}})) begin
        r_dropCnt <= r_dropCnt + 1'b1;
      end
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign Conflict = r_conflict;
  assign Drop_cnt = r_dropCnt;

endmodule
